// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked, gated SR flip-flops with selectable input polarity and
// s=r=1 resolution, plus sticky per-channel conflict flags and a saturating conflict-cycle count.
module sr_ff_bank #(
  parameter int                 WIDTH      = 8,
  parameter int                 ACTIVE_LOW = 0,
  parameter int                 MODE       = 0,
  parameter logic [WIDTH-1:0]   INIT       = '0,
  parameter int                 CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic             AL       = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qn;
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] r_conf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_en_a;
  logic [WIDTH-1:0] w_s_a;
  logic [WIDTH-1:0] w_r_a;
  logic [WIDTH-1:0] w_live;
  logic             w_any_live;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_conf_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Everything downstream works on active-high versions of s, r and en.
  assign w_en_a     = en ^ AL;
  assign w_s_a      = s ^ {WIDTH{AL}};
  assign w_r_a      = r ^ {WIDTH{AL}};
  assign w_live     = w_en_a ? (w_s_a & w_r_a) : '0;
  assign w_any_live = |w_live;

  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_en_a) begin
        if (w_s_a[i] && !w_r_a[i]) begin
          w_q_next[i] = 1'b1;
        end else if (!w_s_a[i] && w_r_a[i]) begin
          w_q_next[i] = 1'b0;
        end else if (w_s_a[i] && w_r_a[i]) begin
          // MODE 0 (and any unlisted value) leaves the bit unchanged.
          if (MODE == 1) begin
            w_q_next[i] = 1'b1;
          end else if (MODE == 2) begin
            w_q_next[i] = 1'b0;
          end else if (MODE == 3) begin
            w_q_next[i] = ~r_q[i];
          end
        end
      end
    end
  end

  // A conflict arriving on the clearing edge wins over the clear.
  assign w_conf_next = (r_conf & ~{WIDTH{clr_err}}) | w_live;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_err) begin
      w_cnt_next    = '0;
      w_cnt_next[0] = w_any_live;
    end else if (w_any_live && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= INIT;
      r_qn   <= ~INIT;
      r_chg  <= '0;
      r_conf <= '0;
      r_cnt  <= '0;
    end else begin
      r_q    <= w_q_next;
      r_qn   <= ~w_q_next;
      r_chg  <= w_q_next ^ r_q;
      r_conf <= w_conf_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign q            = r_q;
  assign qn           = r_qn;
  assign chg          = r_chg;
  assign conflict     = r_conf;
  assign conflict_any = |r_conf;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: five instances (MODE 0..3 active-high, MODE 0 active-low) against a
// rule-level model checked every cycle, plus hand-computed literal expectations.
module tb_sr_ff_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en, clr_err;
  logic [7:0] s, r;
  logic       en4;
  logic [7:0] s4, r4;

  logic [7:0] d_q[5], d_qn[5], d_chg[5], d_conf[5];
  logic       d_any[5];
  logic [3:0] d_cnt[5];
  logic [1:0] cnt3;
  assign d_cnt[3] = {2'b00, cnt3};

  sr_ff_bank #(.WIDTH(8), .ACTIVE_LOW(0), .MODE(0), .INIT(8'hA5), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(d_q[0]), .qn(d_qn[0]), .chg(d_chg[0]), .conflict(d_conf[0]),
    .conflict_any(d_any[0]), .conflict_cnt(d_cnt[0]));
  sr_ff_bank #(.WIDTH(8), .ACTIVE_LOW(0), .MODE(1), .INIT(8'h00), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(d_q[1]), .qn(d_qn[1]), .chg(d_chg[1]), .conflict(d_conf[1]),
    .conflict_any(d_any[1]), .conflict_cnt(d_cnt[1]));
  sr_ff_bank #(.WIDTH(8), .ACTIVE_LOW(0), .MODE(2), .INIT(8'h00), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(d_q[2]), .qn(d_qn[2]), .chg(d_chg[2]), .conflict(d_conf[2]),
    .conflict_any(d_any[2]), .conflict_cnt(d_cnt[2]));
  sr_ff_bank #(.WIDTH(8), .ACTIVE_LOW(0), .MODE(3), .INIT(8'hA5), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(d_q[3]), .qn(d_qn[3]), .chg(d_chg[3]), .conflict(d_conf[3]),
    .conflict_any(d_any[3]), .conflict_cnt(cnt3));
  sr_ff_bank #(.WIDTH(8), .ACTIVE_LOW(1), .MODE(0), .INIT(8'h00), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .s(s4), .r(r4), .clr_err(clr_err),
    .q(d_q[4]), .qn(d_qn[4]), .chg(d_chg[4]), .conflict(d_conf[4]),
    .conflict_any(d_any[4]), .conflict_cnt(d_cnt[4]));

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         p_mode[5] = '{0, 1, 2, 3, 0};
  logic       p_al[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] p_init[5] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00};
  int         p_max[5]  = '{15, 15, 15, 3, 15};

  logic [7:0] m_q[5], m_chg[5], m_conf[5];
  int         m_cnt[5];

  function automatic logic [7:0] next_q(input logic [7:0] cur, input logic [7:0] sa,
                                        input logic [7:0] ra, input logic ea, input int mode);
    logic [7:0] nq;
    nq = cur;
    if (ea) begin
      for (int i = 0; i < 8; i++) begin
        if (sa[i] && !ra[i]) nq[i] = 1'b1;
        else if (!sa[i] && ra[i]) nq[i] = 1'b0;
        else if (sa[i] && ra[i]) begin
          case (mode)
            1:       nq[i] = 1'b1;
            2:       nq[i] = 1'b0;
            3:       nq[i] = ~cur[i];
            default: nq[i] = cur[i];
          endcase
        end
      end
    end
    return nq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 5; k++) begin
      logic [7:0] sa, ra, live, nq;
      logic       ea;
      if (!rst_n) begin
        m_q[k]    <= p_init[k];
        m_chg[k]  <= 8'h00;
        m_conf[k] <= 8'h00;
        m_cnt[k]  <= 0;
      end else begin
        ea   = ((k == 4) ? en4 : en) ^ p_al[k];
        sa   = ((k == 4) ? s4 : s) ^ {8{p_al[k]}};
        ra   = ((k == 4) ? r4 : r) ^ {8{p_al[k]}};
        live = ea ? (sa & ra) : 8'h00;
        nq   = next_q(m_q[k], sa, ra, ea, p_mode[k]);
        m_chg[k]  <= nq ^ m_q[k];
        m_q[k]    <= nq;
        m_conf[k] <= (clr_err ? 8'h00 : m_conf[k]) | live;
        if (clr_err)          m_cnt[k] <= (live != 8'h00) ? 1 : 0;
        else if (live != 8'h00) m_cnt[k] <= (m_cnt[k] < p_max[k]) ? m_cnt[k] + 1 : p_max[k];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 5; k++) begin
        logic [7:0] exp_qn;
        exp_qn = ~m_q[k];
        chk($sformatf("u%0d_q", k),    d_q[k],    m_q[k]);
        chk($sformatf("u%0d_qn", k),   d_qn[k],   exp_qn);
        chk($sformatf("u%0d_chg", k),  d_chg[k],  m_chg[k]);
        chk($sformatf("u%0d_conf", k), d_conf[k], m_conf[k]);
        chk($sformatf("u%0d_any", k),  d_any[k],  |m_conf[k]);
        chk($sformatf("u%0d_cnt", k),  d_cnt[k],  m_cnt[k]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic e, input logic [7:0] sv, input logic [7:0] rv, input logic c);
    @(negedge clk);
    en = e; s = sv; r = rv; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 3, 3};
    rst_n = 1'b1; en = 1'b0; s = 8'h00; r = 8'h00; clr_err = 1'b0;
    en4 = 1'b1; s4 = 8'hFF; r4 = 8'hFF;

    // reset asserted away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q",    d_q[0],    8'hA5);
    chk("rst_qn",   d_qn[0],   8'h5A);
    chk("rst_chg",  d_chg[0],  8'h00);
    chk("rst_conf", d_conf[0], 8'h00);
    chk("rst_cnt",  d_cnt[0],  4'd0);
    check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // basic set/reset, then gated off
    cyc(1'b1, 8'h00, 8'hFF, 1'b0);
    chk("clr_q",   d_q[0],   8'h00);
    chk("clr_chg", d_chg[0], 8'hA5);
    cyc(1'b1, 8'h0F, 8'hF0, 1'b0);
    chk("basic_q",   d_q[0],   8'h0F);
    chk("basic_chg", d_chg[0], 8'h0F);
    cyc(1'b0, 8'hFF, 8'h00, 1'b0);
    chk("gated_q",   d_q[0],   8'h0F);
    chk("gated_chg", d_chg[0], 8'h00);

    // s=r=1 resolution per mode
    cyc(1'b1, 8'h00, 8'hFF, 1'b0);
    cyc(1'b1, 8'h01, 8'h01, 1'b0);
    chk("mode0_q", d_q[0], 8'h00);
    chk("mode1_q", d_q[1], 8'h01);
    chk("mode2_q", d_q[2], 8'h00);
    chk("mode3_q", d_q[3], 8'h01);
    chk("mode3_chg", d_chg[3], 8'h01);
    for (int k = 0; k < 4; k++) chk($sformatf("mode%0d_conf0", k), d_conf[k][0], 1'b1);
    cyc(1'b1, 8'h01, 8'h01, 1'b0);
    chk("mode3_q2",   d_q[3],   8'h00);
    chk("mode3_chg2", d_chg[3], 8'h01);

    // active-low instance
    en4 = 1'b0; s4 = 8'hFE; r4 = 8'hFF;
    cyc(1'b0, 8'h00, 8'h00, 1'b0);
    chk("al_set_q", d_q[4], 8'h01);
    en4 = 1'b1;
    cyc(1'b0, 8'h00, 8'h00, 1'b0);
    chk("al_hold_q", d_q[4], 8'h01);
    r4 = 8'hFE; s4 = 8'hFF;
    cyc(1'b0, 8'h00, 8'h00, 1'b0);
    chk("al_hold_q2",   d_q[4],   8'h01);
    chk("al_hold_chg2", d_chg[4], 8'h00);
    s4 = 8'hFF; r4 = 8'hFF;

    // saturating counter on the 2-bit instance
    cyc(1'b1, 8'h00, 8'h00, 1'b1);
    chk("cnt_clr0",  d_cnt[3],  4'd0);
    chk("conf_clr0", d_conf[3], 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
      chk($sformatf("cnt_sat%0d", i), d_cnt[3], exp_cnt[i]);
    end
    cyc(1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("cnt_clr_live",  d_cnt[3],  4'd1);
    chk("conf_clr_live", d_conf[3], 8'hFF);
    cyc(1'b1, 8'h00, 8'h00, 1'b1);
    chk("cnt_clr",  d_cnt[3],  4'd0);
    chk("conf_clr", d_conf[3], 8'h00);
    chk("any_clr",  d_any[3],  1'b0);

    // reset in the middle of toggling
    cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q",    d_q[3],    8'hA5);
    chk("midrst_qn",   d_qn[3],   8'h5A);
    chk("midrst_chg",  d_chg[3],  8'h00);
    chk("midrst_conf", d_conf[3], 8'h00);
    chk("midrst_any",  d_any[3],  1'b0);
    chk("midrst_cnt",  d_cnt[3],  4'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("resume_q1",   d_q[3],   8'h5A);
    chk("resume_chg1", d_chg[3], 8'hFF);
    cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("resume_q2",   d_q[3],   8'hA5);
    chk("resume_chg2", d_chg[3], 8'hFF);

    // 4-bit counter saturation
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("cnt4_sat", d_cnt[0], 4'd15);

    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
